channel_sweep_ctrl: RTL and testbench

Sweep sequencer for the NVM flash channel model. On a start command it drives a programmed number of cell writes (2-bit voltage levels, round-robin or LFSR-random) into the channel model. It tags each issued level through a delay line matched to the model's pipeline latency and captures the post-retention voltage for each cell. It accumulates per-level statistics (count, sum, min, max) for readout, replacing free-running random stimulus with a bounded, self-checking sweep.

---
 rtl/channel_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_channel_sweep_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_sweep_ctrl.sv
// channel_sweep_ctrl: bounded sweep sequencer for the NVM flash channel model.
// Issues num_cells voltage levels (round-robin or LFSR) to the channel model,
// tags each one through a delay line matched to the model latency, and
// collects per-level retention-voltage statistics (count, sum, min, max).
//
// level_valid/level_out handshake: valid-only, no backpressure. The model
// must accept a level on every cycle that level_valid is high. model_vout is
// qualified by model_rtn_done only in the cycle the matching tag emerges from
// the delay line; it is ignored in every other cycle.
module channel_sweep_ctrl #(
    parameter int          PIPE_LAT  = 30,
    parameter int          CNT_W     = 20,
    parameter int          VOUT_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        num_cells,
    output logic [1:0]              level_out,
    output logic                    level_valid,
    input  logic [VOUT_W-1:0]       model_vout,
    input  logic                    model_rtn_done,
    output logic                    sample_valid,
    output logic [1:0]              sample_level,
    output logic [VOUT_W-1:0]       sample_vout,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        miss_cnt,
    input  logic [1:0]              stat_sel,
    output logic [CNT_W-1:0]        stat_count,
    output logic [VOUT_W+CNT_W-1:0] stat_sum,
    output logic [VOUT_W-1:0]       stat_min,
    output logic [VOUT_W-1:0]       stat_max,
    output logic [1:0]              state_dbg
);

    localparam int SUM_W = VOUT_W + CNT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   n_lat;
    logic               mode_lat;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   collect_cnt;
    logic [1:0]         rr_lvl;
    logic [15:0]        lfsr;

    // Delay line; stage 0 doubles as the registered level_out/level_valid.
    logic               dl_v [PIPE_LAT];
    logic [1:0]         dl_l [PIPE_LAT];

    logic [CNT_W-1:0]   st_cnt [4];
    logic [SUM_W-1:0]   st_sum [4];
    logic [VOUT_W-1:0]  st_min [4];
    logic [VOUT_W-1:0]  st_max [4];

    logic               sweep_go;
    logic               issue_fire;
    logic               last_issue;
    logic               cap_v;
    logic [1:0]         cap_l;
    logic               last_capture;
    logic [1:0]         issue_lvl;
    logic               lfsr_fb;

    // Control decodes shared by the FSM and the datapath.
    always_comb begin
        sweep_go     = (state == S_IDLE) && start;
        issue_fire   = (state == S_ISSUE);
        last_issue   = issue_fire && (issue_cnt == n_lat - CNT_W'(1));
        cap_v        = dl_v[PIPE_LAT-1];
        cap_l        = dl_l[PIPE_LAT-1];
        last_capture = (state == S_DRAIN) && cap_v && (collect_cnt == n_lat - CNT_W'(1));
        issue_lvl    = mode_lat ? lfsr[1:0] : rr_lvl;
        lfsr_fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        state_dbg = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (num_cells == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_capture) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sweep setup latch, issue counter and level generators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_lat     <= '0;
            mode_lat  <= 1'b0;
            issue_cnt <= '0;
            rr_lvl    <= 2'd0;
            lfsr      <= LFSR_SEED;
        end else if (sweep_go) begin
            n_lat     <= num_cells;
            mode_lat  <= mode;
            issue_cnt <= '0;
            rr_lvl    <= 2'd0;
        end else if (issue_fire) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
            if (mode_lat) lfsr   <= {lfsr_fb, lfsr[15:1]};
            else          rr_lvl <= rr_lvl + 2'd1;
        end
    end

    // Tag delay line: a cell's tag reaches the last stage in the cycle the
    // model presents that cell's retention voltage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < PIPE_LAT; j++) begin
                dl_v[j] <= 1'b0;
                dl_l[j] <= 2'd0;
            end
        end else begin
            dl_v[0] <= issue_fire;
            dl_l[0] <= issue_fire ? issue_lvl : 2'd0;
            for (int j = 1; j < PIPE_LAT; j++) begin
                dl_v[j] <= dl_v[j-1];
                dl_l[j] <= dl_l[j-1];
            end
        end
    end

    assign level_valid = dl_v[0];
    assign level_out   = dl_l[0];

    // Capture, miss counting and per-level statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collect_cnt  <= '0;
            miss_cnt     <= '0;
            sample_valid <= 1'b0;
            sample_level <= 2'd0;
            sample_vout  <= '0;
            for (int i = 0; i < 4; i++) begin
                st_cnt[i] <= '0;
                st_sum[i] <= '0;
                st_min[i] <= '1;
                st_max[i] <= '0;
            end
        end else if (sweep_go) begin
            collect_cnt  <= '0;
            miss_cnt     <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                st_cnt[i] <= '0;
                st_sum[i] <= '0;
                st_min[i] <= '1;
                st_max[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (cap_v) begin
                collect_cnt <= collect_cnt + CNT_W'(1);
                if (model_rtn_done) begin
                    sample_valid  <= 1'b1;
                    sample_level  <= cap_l;
                    sample_vout   <= model_vout;
                    st_cnt[cap_l] <= st_cnt[cap_l] + CNT_W'(1);
                    st_sum[cap_l] <= st_sum[cap_l] + SUM_W'(model_vout);
                    if (model_vout < st_min[cap_l]) st_min[cap_l] <= model_vout;
                    if (model_vout > st_max[cap_l]) st_max[cap_l] <= model_vout;
                end else begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign stat_count = st_cnt[stat_sel];
    assign stat_sum   = st_sum[stat_sel];
    assign stat_min   = st_min[stat_sel];
    assign stat_max   = st_max[stat_sel];

endmodule

// File: tb/tb_channel_sweep_ctrl.sv
// Bench for channel_sweep_ctrl. Each sweep is expanded up front into a
// cycle-indexed timeline of what the outputs must show (issue window, capture
// slots, done cycle); a stub channel model drives the capture slots from the
// same timeline, and a compare process checks every cycle.
module tb_channel_sweep_ctrl;

    localparam int          PIPE_LAT = 30;
    localparam int          CNT_W    = 20;
    localparam int          VOUT_W   = 16;
    localparam int          SUM_W    = VOUT_W + CNT_W;
    localparam int          MAXC     = 4096;
    localparam logic [15:0] SEED     = 16'hACE1;

    // Clock / reset / DUT signals
    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               mode;
    logic [CNT_W-1:0]   num_cells;
    logic [1:0]         level_out;
    logic               level_valid;
    logic [VOUT_W-1:0]  model_vout = '0;
    logic               model_rtn_done = 1'b0;
    logic               sample_valid;
    logic [1:0]         sample_level;
    logic [VOUT_W-1:0]  sample_vout;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   miss_cnt;
    logic [1:0]         stat_sel = 2'd0;
    logic [CNT_W-1:0]   stat_count;
    logic [SUM_W-1:0]   stat_sum;
    logic [VOUT_W-1:0]  stat_min;
    logic [VOUT_W-1:0]  stat_max;
    logic [1:0]         state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    channel_sweep_ctrl #(
        .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W), .VOUT_W(VOUT_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num_cells(num_cells),
        .level_out(level_out), .level_valid(level_valid),
        .model_vout(model_vout), .model_rtn_done(model_rtn_done),
        .sample_valid(sample_valid), .sample_level(sample_level), .sample_vout(sample_vout),
        .busy(busy), .done(done), .miss_cnt(miss_cnt), .stat_sel(stat_sel),
        .stat_count(stat_count), .stat_sum(stat_sum), .stat_min(stat_min),
        .stat_max(stat_max), .state_dbg(state_dbg)
    );

    // Expected timeline, indexed by cycle (cycle c = interval after edge c)
    bit          exp_lv   [MAXC];
    logic [1:0]  exp_lo   [MAXC];
    bit          exp_sv   [MAXC];
    logic [1:0]  exp_sl   [MAXC];
    logic [15:0] exp_so   [MAXC];
    bit          exp_miss [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_done [MAXC];
    bit          exp_clr  [MAXC];
    // Stub model drive per cycle
    bit          st_on    [MAXC];
    bit          st_rd    [MAXC];
    logic [15:0] st_vo    [MAXC];

    // Behavioural statistics model
    logic [CNT_W-1:0]  m_cnt [4];
    logic [SUM_W-1:0]  m_sum [4];
    logic [VOUT_W-1:0] m_min [4];
    logic [VOUT_W-1:0] m_max [4];
    logic [CNT_W-1:0]  m_miss;
    logic [15:0]       m_lfsr = SEED;

    logic [1:0] golden [5] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = '0;
            m_sum[i] = '0;
            m_min[i] = '1;
            m_max[i] = '0;
        end
        m_miss = '0;
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            exp_lv[c] = 0; exp_lo[c] = 0; exp_sv[c] = 0; exp_sl[c] = 0; exp_so[c] = 0;
            exp_miss[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_clr[c] = 0;
            st_on[c] = 0; st_rd[c] = 0; st_vo[c] = 0;
        end
    endtask

    // Expand a sweep accepted at edge k into the expected timeline.
    task automatic schedule_sweep(input int k, input int n, input bit md,
                                  input int drop_i, input bit rnd);
        int          rr;
        int          e;
        logic [1:0]  lv;
        logic [15:0] v;
        bit          ok;
        rr = 0;
        exp_clr[k] = 1;
        if (n == 0) begin
            exp_done[k] = 1;
        end else begin
            for (int i = 1; i <= n; i++) begin
                if (md) begin
                    lv = m_lfsr[1:0];
                    m_lfsr = lfsr_next(m_lfsr);
                end else begin
                    lv = 2'(rr);
                    rr = (rr + 1) % 4;
                end
                exp_lv[k+i] = 1;
                exp_lo[k+i] = lv;
                e  = k + i + PIPE_LAT;
                v  = rnd ? 16'($urandom) : 16'(1000 * int'(lv) + 5);
                ok = rnd ? ($urandom_range(0, 4) != 0) : (i != drop_i);
                st_on[e-1] = 1;
                st_vo[e-1] = v;
                st_rd[e-1] = ok;
                if (ok) begin
                    exp_sv[e] = 1; exp_sl[e] = lv; exp_so[e] = v;
                end else begin
                    exp_miss[e] = 1;
                end
            end
            for (int c = k; c < k + n + PIPE_LAT; c++) exp_busy[c] = 1;
            exp_done[k+n+PIPE_LAT] = 1;
        end
    endtask

    // Stub channel model: real results in capture slots, noise elsewhere.
    always @(posedge clk) begin
        #1;
        if (cyc < MAXC && st_on[cyc]) begin
            model_vout     = st_vo[cyc];
            model_rtn_done = st_rd[cyc];
        end else begin
            model_vout     = 16'($urandom);
            model_rtn_done = 1'($urandom);
        end
    end

    // Compare process: advance the model, then check every output.
    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < MAXC) begin
            if (!reset) begin
                model_clear();
            end else begin
                if (exp_clr[c]) model_clear();
                if (exp_sv[c]) begin
                    m_cnt[exp_sl[c]] = m_cnt[exp_sl[c]] + 1'b1;
                    m_sum[exp_sl[c]] = m_sum[exp_sl[c]] + SUM_W'(exp_so[c]);
                    if (exp_so[c] < m_min[exp_sl[c]]) m_min[exp_sl[c]] = exp_so[c];
                    if (exp_so[c] > m_max[exp_sl[c]]) m_max[exp_sl[c]] = exp_so[c];
                end
                if (exp_miss[c]) m_miss = m_miss + 1'b1;
            end
            chk("level_valid", 64'(level_valid), 64'(exp_lv[c]));
            if (exp_lv[c] || !reset) chk("level_out", 64'(level_out), 64'(exp_lo[c]));
            chk("sample_valid", 64'(sample_valid), 64'(exp_sv[c]));
            if (exp_sv[c] || !reset) begin
                chk("sample_level", 64'(sample_level), 64'(exp_sl[c]));
                chk("sample_vout", 64'(sample_vout), 64'(exp_so[c]));
            end
            chk("busy", 64'(busy), 64'(exp_busy[c]));
            chk("done", 64'(done), 64'(exp_done[c]));
            chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
            for (int s = 0; s < 4; s++) begin
                stat_sel = 2'(s);
                #1;
                chk("stat_count", 64'(stat_count), 64'(m_cnt[s]));
                chk("stat_sum", 64'(stat_sum), 64'(m_sum[s]));
                chk("stat_min", 64'(stat_min), 64'(m_min[s]));
                chk("stat_max", 64'(stat_max), 64'(m_max[s]));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sweep(input int n, input bit md, input int drop_i,
                               input bit rnd, output int k);
        start     = 1'b1;
        mode      = md;
        num_cells = CNT_W'(n);
        k = cyc + 1;
        schedule_sweep(k, n, md, drop_i, rnd);
        tick();
        start     = 1'b0;
        mode      = 1'($urandom);
        num_cells = CNT_W'($urandom);
    endtask

    task automatic finish_sweep(input int k, input int n);
        int d;
        d = (n == 0) ? k : k + n + PIPE_LAT;
        while (cyc < d - 1) tick();
        if (cyc == d - 1) chk("done_early", 64'(done), 64'd0);
        while (cyc < d) tick();
        chk("done_at_end", 64'(done), 64'd1);
        tick();
    endtask

    task automatic golden_check(input int k);
        for (int i = 1; i <= 5; i++) begin
            while (cyc < k + i) tick();
            chk("lfsr_golden", 64'(level_out), 64'(golden[i-1]));
        end
    endtask

    // Stimulus
    initial begin
        int k;
        int n;
        logic [CNT_W-1:0] tot;
        clear_from(0);
        model_clear();
        reset = 1'b0; start = 1'b0; mode = 1'b0; num_cells = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level_valid", 64'(level_valid), 64'd0);
        chk("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;
        tick();

        // Round-robin, N=8
        begin_sweep(8, 1'b0, 0, 1'b0, k);
        finish_sweep(k, 8);
        chk("pin_rr8_cnt1", 64'(m_cnt[1]), 64'd2);
        chk("pin_rr8_sum3", 64'(m_sum[3]), 64'd6010);
        chk("pin_rr8_min2", 64'(m_min[2]), 64'd2005);
        chk("pin_rr8_max0", 64'(m_max[0]), 64'd5);
        chk("rr8_miss", 64'(miss_cnt), 64'd0);

        // Round-robin, N=6, cell 3 dropped
        begin_sweep(6, 1'b0, 3, 1'b0, k);
        finish_sweep(k, 6);
        chk("drop_miss", 64'(miss_cnt), 64'd1);
        chk("pin_drop_cnt2", 64'(m_cnt[2]), 64'd0);
        chk("pin_drop_min2", 64'(m_min[2]), 64'hFFFF);
        chk("pin_drop_cnt0", 64'(m_cnt[0]), 64'd2);

        // Zero-length sweep
        begin_sweep(0, 1'b0, 0, 1'b0, k);
        finish_sweep(k, 0);
        tot = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
        chk("pin_zero_cleared", 64'(tot), 64'd0);

        // start during ISSUE is ignored, then a fresh N=4 sweep
        begin_sweep(10, 1'b0, 0, 1'b0, k);
        tick(); tick();
        start = 1'b1; num_cells = CNT_W'(5); mode = 1'b1;
        tick();
        start = 1'b0;
        finish_sweep(k, 10);
        begin_sweep(4, 1'b0, 0, 1'b0, k);
        finish_sweep(k, 4);
        for (int l = 0; l < 4; l++) chk("pin_n4_cnt", 64'(m_cnt[l]), 64'd1);

        // LFSR, N=1000
        begin_sweep(1000, 1'b1, 0, 1'b0, k);
        golden_check(k);
        finish_sweep(k, 1000);
        tot = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
        chk("pin_lfsr_total", 64'(tot), 64'd1000);

        // Randomized sweeps
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 40);
            begin_sweep(n, 1'($urandom_range(0, 1)), 0, 1'b1, k);
            finish_sweep(k, n);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset asserted mid-ISSUE
        begin_sweep(200, 1'b1, 0, 1'b1, k);
        while (cyc < k + 50) tick();
        clear_from(cyc);
        m_lfsr = SEED;
        reset  = 1'b0;
        tick();
        chk("midrst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b1;
        repeat (PIPE_LAT + 5) tick();
        begin_sweep(5, 1'b1, 0, 1'b0, k);
        golden_check(k);
        finish_sweep(k, 5);

        repeat (3) tick();
        chk("cycle_budget", 64'(cyc < MAXC), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
